// File: rtl/home_pkg.sv
// Shared definitions for the home automation controller: sensor indices,
// temperature widths and averaging-window geometry.
package home_pkg;

    localparam int ST_W         = 7;
    localparam int ST_SUM_W     = 9;
    localparam int NUM_BIN_SNS  = 4;
    localparam int ST_AVG_DEPTH = 4;
    localparam int ST_AVG_SHIFT = 2;

    typedef enum logic [1:0] {
        SNS_FD = 2'd0,
        SNS_RD = 2'd1,
        SNS_W  = 2'd2,
        SNS_FA = 2'd3
    } sensor_e;

endpackage

// File: rtl/sensor_debounce.sv
// One binary sensor channel: two-flop synchroniser, persistence counter and
// output flop. With fast_assert set, a rising level bypasses the counter.
module sensor_debounce #(
    parameter int DB_CYCLES   = 16,
    parameter int CNT_W       = 5,
    parameter bit fast_assert = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             syncA_q;
    logic             syncB_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Any edge where the synchronised level agrees with the output restarts the count.
    always_comb begin
        level_d = level_q;
        count_d = '0;
        if (syncB_q != level_q) begin
            if (fast_assert && syncB_q) begin
                level_d = 1'b1;
            end else if (count_q == CNT_LAST) begin
                level_d = syncB_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            syncA_q <= 1'b0;
            syncB_q <= 1'b0;
            level_q <= 1'b0;
            count_q <= '0;
        end else begin
            syncA_q <= raw_i;
            syncB_q <= syncA_q;
            level_q <= level_d;
            count_q <= count_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/sensor_cond.sv
// Input conditioning for the controller FSM: debounced door/window/fire levels
// and a 4-tap moving-average temperature. SENSOR_COND_FIRE_FAST_EN makes the
// fire channel assert without debounce.
module sensor_cond
    import home_pkg::*;
#(
    parameter int              DB_CYCLES  = 16,
    parameter int              CNT_W      = 5,
    parameter int              SAMPLE_DIV = 8,
    parameter logic [ST_W-1:0] ST_INIT    = 7'd40
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            raw_sfd,
    input  logic            raw_srd,
    input  logic            raw_sw,
    input  logic            raw_sfa,
    input  logic [ST_W-1:0] raw_st,
    output logic            SFD,
    output logic            SRD,
    output logic            SW,
    output logic            SFA,
    output logic [ST_W-1:0] ST,
    output logic            st_valid
);

`ifdef SENSOR_COND_FIRE_FAST_EN
    localparam bit FAST_FA = 1'b1;
`else
    localparam bit FAST_FA = 1'b0;
`endif

    localparam int              TICK_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [2:0]      FILL_FULL = 3'(ST_AVG_DEPTH);
    localparam logic [2:0]      FILL_LAST = 3'(ST_AVG_DEPTH - 1);

    logic [NUM_BIN_SNS-1:0] rawVec;
    logic [NUM_BIN_SNS-1:0] levelVec;

    assign rawVec[SNS_FD] = raw_sfd;
    assign rawVec[SNS_RD] = raw_srd;
    assign rawVec[SNS_W]  = raw_sw;
    assign rawVec[SNS_FA] = raw_sfa;

    for (genvar i = 0; i < NUM_BIN_SNS; i++) begin : g_chan
        sensor_debounce #(
            .DB_CYCLES  (DB_CYCLES),
            .CNT_W      (CNT_W),
            .fast_assert(FAST_FA && (i == int'(SNS_FA)))
        ) u_debounce (
            .clk_i  (Clk),
            .rst_i  (Rst),
            .raw_i  (rawVec[i]),
            .level_o(levelVec[i])
        );
    end

    assign SFD = levelVec[SNS_FD];
    assign SRD = levelVec[SNS_RD];
    assign SW  = levelVec[SNS_W];
    assign SFA = levelVec[SNS_FA];

    logic [ST_W-1:0]     stSyncA_q;
    logic [ST_W-1:0]     stSyncB_q;
    logic [TICK_W-1:0]   tick_q;
    logic [TICK_W-1:0]   tick_d;
    logic [ST_W-1:0]     sampleBuf_q [ST_AVG_DEPTH];
    logic [ST_W-1:0]     sampleBuf_d [ST_AVG_DEPTH];
    logic [ST_SUM_W-1:0] sum_q;
    logic [ST_SUM_W-1:0] sum_d;
    logic [2:0]          fill_q;
    logic [2:0]          fill_d;
    logic [ST_W-1:0]     st_q;
    logic [ST_W-1:0]     st_d;
    logic                valid_q;
    logic                valid_d;
    logic                sampleTick;

    // The running sum always contains the oldest sample, so subtracting it never underflows.
    always_comb begin
        sampleTick  = (tick_q == TICK_LAST);
        tick_d      = sampleTick ? '0 : tick_q + 1'b1;
        sampleBuf_d = sampleBuf_q;
        sum_d       = sum_q;
        fill_d      = fill_q;
        st_d        = st_q;
        valid_d     = valid_q;
        if (sampleTick) begin
            sampleBuf_d[0] = stSyncB_q;
            for (int k = 1; k < ST_AVG_DEPTH; k++) begin
                sampleBuf_d[k] = sampleBuf_q[k-1];
            end
            sum_d = sum_q + ST_SUM_W'(stSyncB_q) - ST_SUM_W'(sampleBuf_q[ST_AVG_DEPTH-1]);
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 3'd1;
            end
            if (fill_q >= FILL_LAST) begin
                valid_d = 1'b1;
                st_d    = sum_d[ST_SUM_W-1:ST_AVG_SHIFT];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stSyncA_q <= '0;
            stSyncB_q <= '0;
            tick_q    <= '0;
            for (int k = 0; k < ST_AVG_DEPTH; k++) begin
                sampleBuf_q[k] <= '0;
            end
            sum_q     <= '0;
            fill_q    <= '0;
            st_q      <= ST_INIT;
            valid_q   <= 1'b0;
        end else begin
            stSyncA_q <= raw_st;
            stSyncB_q <= stSyncA_q;
            tick_q    <= tick_d;
            for (int k = 0; k < ST_AVG_DEPTH; k++) begin
                sampleBuf_q[k] <= sampleBuf_d[k];
            end
            sum_q     <= sum_d;
            fill_q    <= fill_d;
            st_q      <= st_d;
            valid_q   <= valid_d;
        end
    end

    assign ST       = st_q;
    assign st_valid = valid_q;

endmodule

// File: tb/tb_sensor_cond.sv
// Directed bench for sensor_cond with DB_CYCLES=4, SAMPLE_DIV=2, ST_INIT=40;
// expected fire-channel latency follows SENSOR_COND_FIRE_FAST_EN.
module tb_sensor_cond;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       raw_sfd;
    logic       raw_srd;
    logic       raw_sw;
    logic       raw_sfa;
    logic [6:0] raw_st;
    logic       SFD;
    logic       SRD;
    logic       SW;
    logic       SFA;
    logic [6:0] ST;
    logic       st_valid;

    int errorCount = 0;
    int checkCount = 0;

    sensor_cond #(
        .DB_CYCLES (4),
        .CNT_W     (5),
        .SAMPLE_DIV(2),
        .ST_INIT   (7'd40)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .raw_sfd (raw_sfd),
        .raw_srd (raw_srd),
        .raw_sw  (raw_sw),
        .raw_sfa (raw_sfa),
        .raw_st  (raw_st),
        .SFD     (SFD),
        .SRD     (SRD),
        .SW      (SW),
        .SFA     (SFA),
        .ST      (ST),
        .st_valid(st_valid)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Expected vector is {SFD, SRD, SW, SFA}.
    task automatic checkBinary(input string tag, input logic [3:0] expected);
        checkOutput({tag, "_SFD"}, 32'(SFD), 32'(expected[3]));
        checkOutput({tag, "_SRD"}, 32'(SRD), 32'(expected[2]));
        checkOutput({tag, "_SW"},  32'(SW),  32'(expected[1]));
        checkOutput({tag, "_SFA"}, 32'(SFA), 32'(expected[0]));
    endtask

    task automatic applyStimulus(input logic fd, input logic rd, input logic w, input logic fa,
                                 input logic [6:0] st);
        raw_sfd = fd;
        raw_srd = rd;
        raw_sw  = w;
        raw_sfa = fa;
        raw_st  = st;
    endtask

    // Leaves the bench 1 time unit after the n-th rising edge.
    task automatic stepClock(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        // Reset held with every raw input high.
        Rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 7'd127);
        for (int i = 0; i < 3; i++) begin
            stepClock(1);
            checkBinary("rst", 4'b0000);
            checkOutput("rst_ST", 32'(ST), 32'd40);
            checkOutput("rst_valid", 32'(st_valid), 32'd0);
        end

        // Filter priming with 20; edge R is the last reset edge, ticks fall on R+2, R+4, ...
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd20);
        stepClock(2);
        Rst = 1'b0;
        stepClock(7);
        checkOutput("prime_valid_early", 32'(st_valid), 32'd0);
        checkOutput("prime_ST_early", 32'(ST), 32'd40);
        stepClock(1);
        checkOutput("prime_valid", 32'(st_valid), 32'd1);
        // First tick caught the synchroniser still at 0: (0+20+20+20)>>2
        checkOutput("prime_ST", 32'(ST), 32'd15);
        stepClock(2);
        checkOutput("steady_ST20", 32'(ST), 32'd20);

        // Step to 100 just after a tick; the next tick still sees 20.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd100);
        stepClock(2);
        checkOutput("step_ST_hold", 32'(ST), 32'd20);
        for (int k = 0; k < 4; k++) begin
            stepClock(2);
            checkOutput($sformatf("step_ST_%0d", k), 32'(ST), 32'(40 + 20 * k));
        end

        // Extreme input: 100 -> 127 walks 100,106,113,120,127 and holds without wrap.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd127);
        stepClock(2);
        checkOutput("max_ST_hold", 32'(ST), 32'd100);
        stepClock(2);
        checkOutput("max_ST_1", 32'(ST), 32'd106);
        stepClock(2);
        checkOutput("max_ST_2", 32'(ST), 32'd113);
        stepClock(2);
        checkOutput("max_ST_3", 32'(ST), 32'd120);
        stepClock(2);
        checkOutput("max_ST_4", 32'(ST), 32'd127);
        stepClock(2);
        checkOutput("max_ST_5", 32'(ST), 32'd127);
        checkOutput("max_valid", 32'(st_valid), 32'd1);

        // raw_sfd rises; first sampled at edge E, SFD must follow at E+5.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd127);
        stepClock(5);
        checkBinary("sfd_E4", 4'b0000);
        stepClock(1);
        checkBinary("sfd_E5", 4'b1000);

        // Three-cycle raw_srd pulse is rejected.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 7'd127);
        stepClock(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd127);
        for (int i = 0; i < 8; i++) begin
            stepClock(1);
            checkOutput($sformatf("srd_pulse_%0d", i), 32'(SRD), 32'd0);
        end

        // raw_sw toggling every cycle never reaches the output.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, (i % 2) == 0, 1'b0, 7'd127);
            stepClock(1);
            checkOutput($sformatf("sw_toggle_%0d", i), 32'(SW), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd127);
        stepClock(4);

        // Fire assertion latency depends on the build.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 7'd127);
`ifdef SENSOR_COND_FIRE_FAST_EN
        stepClock(2);
        checkOutput("sfa_fast_E1", 32'(SFA), 32'd0);
        stepClock(1);
        checkOutput("sfa_fast_E2", 32'(SFA), 32'd1);
`else
        stepClock(5);
        checkOutput("sfa_slow_E4", 32'(SFA), 32'd0);
        stepClock(1);
        checkOutput("sfa_slow_E5", 32'(SFA), 32'd1);
`endif
        stepClock(3);

        // Two-cycle low glitch on fire is ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd127);
        stepClock(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 7'd127);
        for (int i = 0; i < 8; i++) begin
            stepClock(1);
            checkOutput($sformatf("sfa_glitch_%0d", i), 32'(SFA), 32'd1);
        end

        // Fire deassertion is debounced in both builds.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd127);
        stepClock(5);
        checkOutput("sfa_fall_E4", 32'(SFA), 32'd1);
        stepClock(1);
        checkOutput("sfa_fall_E5", 32'(SFA), 32'd0);

        // Simultaneous changes on three channels resolve together at E+5.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 7'd127);
        stepClock(5);
        checkBinary("multi_E4", 4'b1000);
        stepClock(1);
        checkBinary("multi_E5", 4'b0110);

        // Reset mid-count and mid-fill; R' is the aligning reset edge.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd60);
        Rst = 1'b1;
        stepClock(1);
        checkBinary("rst2", 4'b0000);
        Rst = 1'b0;
        stepClock(2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'd60);
        stepClock(3);
        Rst = 1'b1;
        stepClock(1);
        checkOutput("midrst_SW", 32'(SW), 32'd0);
        checkOutput("midrst_valid", 32'(st_valid), 32'd0);
        checkOutput("midrst_ST", 32'(ST), 32'd40);
        Rst = 1'b0;
        stepClock(5);
        checkOutput("midrst_SW_E4", 32'(SW), 32'd0);
        checkOutput("midrst_valid_t2", 32'(st_valid), 32'd0);
        stepClock(1);
        checkOutput("midrst_SW_E5", 32'(SW), 32'd1);
        checkOutput("midrst_valid_t3", 32'(st_valid), 32'd0);
        checkOutput("midrst_ST_t3", 32'(ST), 32'd40);
        stepClock(2);
        checkOutput("midrst_valid_t4", 32'(st_valid), 32'd1);
        // First fresh tick again sees a cleared synchroniser: (0+60+60+60)>>2
        checkOutput("midrst_ST_t4", 32'(ST), 32'd45);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
